// File: rtl/object_pixel_fetch_if.sv
// Object pixel fetch bus: descriptor/frame control, scan request, sprite ROM port and pixel result.
// master = updater/scan/ROM side, slave = object_pixel_fetch.
interface object_pixel_fetch_if #(
  parameter int unsigned DATA_LEN   = 48,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10,
  parameter int unsigned TYPE_W     = 6,
  parameter int unsigned SLOT_SHIFT = 12,
  parameter int unsigned COLOR_W    = 12,
  parameter int unsigned CNT_W      = 16
);
  logic                         frame_start;
  logic [DATA_LEN-1:0]          obj;
  logic                         pix_req;
  logic [X_W-1:0]               hpos;
  logic [Y_W-1:0]               vpos;
  logic [TYPE_W+SLOT_SHIFT-1:0] rom_addr;
  logic [COLOR_W-1:0]           rom_data;
  logic                         pix_valid;
  logic                         pix_hit;
  logic [COLOR_W-1:0]           pix_color;
  logic [CNT_W-1:0]             last_frame_hits;

  modport master (
    output frame_start, obj, pix_req, hpos, vpos, rom_data,
    input  rom_addr, pix_valid, pix_hit, pix_color, last_frame_hits
  );

  modport slave (
    input  frame_start, obj, pix_req, hpos, vpos, rom_data,
    output rom_addr, pix_valid, pix_hit, pix_color, last_frame_hits
  );
endinterface

// File: rtl/object_pixel_fetch.sv
// Snapshots one object descriptor per frame and, for each scanned pixel, tests coverage
// and fetches the sprite word; two-stage pipeline plus a per-frame hit counter.
module object_pixel_fetch #(
  parameter int unsigned DATA_LEN   = 48,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10,
  parameter int unsigned SZ_W       = 8,
  parameter int unsigned TYPE_W     = 6,
  parameter int unsigned SLOT_SHIFT = 12,
  parameter int unsigned COLOR_W    = 12,
  parameter int unsigned TRANSP     = 0,
  parameter int unsigned CNT_W      = 16
) (
  input logic               clk,
  input logic               reset,
  object_pixel_fetch_if.slave bus
);
  // Descriptor layout, LSB first: x, y, width, height, type; remaining bits reserved.
  localparam int unsigned X_LSB  = 0;
  localparam int unsigned Y_LSB  = X_LSB + X_W;
  localparam int unsigned W_LSB  = Y_LSB + Y_W;
  localparam int unsigned H_LSB  = W_LSB + SZ_W;
  localparam int unsigned T_LSB  = H_LSB + SZ_W;
  localparam int unsigned USED_W = T_LSB + TYPE_W;
  localparam int unsigned XE_W   = X_W + 1;
  localparam int unsigned YE_W   = Y_W + 1;
  localparam int unsigned LIN_W  = Y_W + SZ_W + 1;

  logic [USED_W-1:0]   shadow;
  logic                unused_obj_bits;
  logic [X_W-1:0]      x_s;
  logic [Y_W-1:0]      y_s;
  logic [SZ_W-1:0]     w_s;
  logic [SZ_W-1:0]     h_s;
  logic [TYPE_W-1:0]   t_s;
  logic [XE_W-1:0]     x_end;
  logic [YE_W-1:0]     y_end;
  logic [X_W-1:0]      dx;
  logic [Y_W-1:0]      dy;
  logic [SLOT_SHIFT-1:0] offs_c;
  logic                in_c;
  logic                hit2_c;
  logic                v1;
  logic                h1;
  logic [CNT_W-1:0]    hit_cnt;
  logic [CNT_W-1:0]    cnt_next_c;

  assign unused_obj_bits = ^bus.obj[DATA_LEN-1:USED_W];

  assign x_s = shadow[X_LSB +: X_W];
  assign y_s = shadow[Y_LSB +: Y_W];
  assign w_s = shadow[W_LSB +: SZ_W];
  assign h_s = shadow[H_LSB +: SZ_W];
  assign t_s = shadow[T_LSB +: TYPE_W];

  // Coverage test with carry-extended ends so boxes clip at the screen edge instead of wrapping.
  always_comb begin
    x_end  = XE_W'(x_s) + XE_W'(w_s);
    y_end  = YE_W'(y_s) + YE_W'(h_s);
    dx     = bus.hpos - x_s;
    dy     = bus.vpos - y_s;
    offs_c = SLOT_SHIFT'(LIN_W'(dy) * LIN_W'(w_s) + LIN_W'(dx));
    in_c   = (w_s != '0) && (h_s != '0) &&
             (bus.hpos >= x_s) && (XE_W'(bus.hpos) < x_end) &&
             (bus.vpos >= y_s) && (YE_W'(bus.vpos) < y_end);
  end

  assign hit2_c = h1 && (bus.rom_data != COLOR_W'(TRANSP));

  always_comb begin
    cnt_next_c = hit_cnt;
    if (bus.pix_hit && (hit_cnt != '1)) cnt_next_c = hit_cnt + CNT_W'(1);
  end

  // Frame shadow: obj may change mid-frame without affecting the current scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                shadow <= '0;
    else if (bus.frame_start) shadow <= bus.obj[USED_W-1:0];
  end

  // Stage 1: coverage decision and ROM address; the address holds on misses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1           <= 1'b0;
      h1           <= 1'b0;
      bus.rom_addr <= '0;
    end else begin
      v1 <= bus.pix_req;
      h1 <= bus.pix_req && in_c;
      if (bus.pix_req && in_c) bus.rom_addr <= {t_s, offs_c};
    end
  end

  // Stage 2: combine with the ROM word returned for the stage-1 address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.pix_valid <= 1'b0;
      bus.pix_hit   <= 1'b0;
      bus.pix_color <= '0;
    end else begin
      bus.pix_valid <= v1;
      bus.pix_hit   <= hit2_c;
      bus.pix_color <= hit2_c ? bus.rom_data : '0;
    end
  end

  // Saturating hit counter; frame_start publishes the total including this cycle's hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt             <= '0;
      bus.last_frame_hits <= '0;
    end else if (bus.frame_start) begin
      hit_cnt             <= '0;
      bus.last_frame_hits <= cnt_next_c;
    end else begin
      hit_cnt <= cnt_next_c;
    end
  end
endmodule
